fifo_rd_stream: RTL and testbench

Read-side drain engine for the async FIFO, running entirely in the read clock domain. It pops words from the FIFO read port using the FIFO's empty flag and fixed RAM read latency, and absorbs in-flight words in a small internal buffer. It presents them as a valid/ready stream with packet framing (last flag every PKT_LEN words) and running word and packet counters. It allows downstream consumers with arbitrary backpressure to attach to the FIFO without losing or duplicating words.

---
 rtl/fifo_rd_stream_if.sv | 48 ++++
 rtl/fifo_rd_stream.sv | 137 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Groups the FIFO read-port signals and the outgoing valid/ready stream of the
// read-side drain engine into one bundle.
//
//   fifo_empty  FIFO empty flag (read clock domain)
//   fifo_rd_en  pop request towards the FIFO
//   fifo_dout   FIFO read data, valid a fixed latency after a pop
//   m_valid     stream word valid
//   m_ready     downstream accept
//   m_data      stream data
//   m_last      final word of a packet
//
// Modports:
//   master  the drain engine (drives fifo_rd_en and the stream outputs)
//   slave   the environment (FIFO read port plus downstream consumer)
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int RD_DW = 8
);
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [RD_DW-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [RD_DW-1:0] m_data;
  logic             m_last;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data,
    output m_last
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data,
    input  m_last
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Read-side drain engine for an async FIFO. Pops words using the FIFO empty
// flag, tracks the fixed RAM read latency with a shift register of issue bits,
// catches returning words in a small circular buffer and presents them as a
// valid/ready stream with packet framing and running counters.
//
// Ports:
//   rclk      read-domain clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       fifo_rd_stream_if.master (FIFO read port + output stream)
//   word_cnt  words accepted downstream, wraps modulo 2^CNT_W
//   pkt_cnt   packets completed, wraps modulo 2^CNT_W
//   busy      a word is buffered or still in flight from the FIFO RAM
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int RD_DW   = 8,
  parameter int RD_LAT  = 1,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rst_n,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             busy
);

  // One slot per word that can be in flight plus one that is being presented.
  localparam int BUF_DEPTH = RD_LAT + 1;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W     = OCC_W + 1;
  localparam int BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [RD_LAT-1:0] trk_q, trk_d;
  logic [RD_DW-1:0]  buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [OCC_W-1:0]  inflight;
  logic [SUM_W-1:0]  committed;
  logic              wr;
  logic              pop;
  logic              valid;
  logic              at_last;
  logic              rd_en;

  // Issue tracker: bit 0 records this cycle's pop, the top bit marks the
  // cycle in which the matching word is present on fifo_dout.
  assign trk_d[0] = rd_en;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_trk
      assign trk_d[gi] = trk_q[gi-1];
    end
  endgenerate

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(trk_q[i]);
    end
  end

  assign wr      = trk_q[RD_LAT-1];
  assign valid   = (occ_q != '0);
  assign pop     = valid & bus.m_ready;
  assign at_last = (beat_q == BEAT_W'(PKT_LEN - 1));

  // Space already promised to buffered and in-flight words; the slot freed by
  // a same-cycle pop can be reused immediately, which keeps 1 word/cycle.
  assign committed = SUM_W'(occ_q) + SUM_W'(inflight) - SUM_W'(pop);
  assign rd_en     = rst_n & ~bus.fifo_empty & (committed < SUM_W'(BUF_DEPTH));

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = valid;
  assign bus.m_data     = buf_q[head_q];
  assign bus.m_last     = valid & at_last;

  assign word_cnt = word_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign busy     = valid | (trk_q != '0);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q + OCC_W'(wr) - OCC_W'(pop);
    beat_d     = beat_q;
    word_cnt_d = word_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (wr) begin
      tail_d = (tail_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d     = (head_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
      word_cnt_d = word_cnt_q + CNT_W'(1);
      if (at_last) begin
        beat_d    = '0;
        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      beat_q     <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      trk_q      <= trk_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      beat_q     <= beat_d;
      word_cnt_q <= word_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      if (wr) begin
        buf_q[tail_q] <= bus.fifo_dout;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Two instances: A (RD_LAT=1, PKT_LEN=16, CNT_W=16) and B (RD_LAT=3,
// PKT_LEN=1, CNT_W=4), each fed by a behavioural FIFO read-port model with the
// matching read latency. Expected words and last flags are queued when they
// are written into the FIFO model and popped on each accepted beat.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;

  localparam int LAT_A = 1;
  localparam int PL_A  = 16;
  localparam int LAT_B = 3;
  localparam int PL_B  = 1;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.RD_DW(8)) bus_a ();
  fifo_rd_stream_if #(.RD_DW(8)) bus_b ();

  logic [15:0] wc_a, pc_a;
  logic [3:0]  wc_b, pc_b;
  logic        busy_a, busy_b;

  fifo_rd_stream #(.RD_DW(8), .RD_LAT(LAT_A), .PKT_LEN(PL_A), .CNT_W(16)) dut_a (
    .rclk(clk), .rst_n(rst_n), .bus(bus_a),
    .word_cnt(wc_a), .pkt_cnt(pc_a), .busy(busy_a)
  );

  fifo_rd_stream #(.RD_DW(8), .RD_LAT(LAT_B), .PKT_LEN(PL_B), .CNT_W(4)) dut_b (
    .rclk(clk), .rst_n(rst_n), .bus(bus_b),
    .word_cnt(wc_b), .pkt_cnt(pc_b), .busy(busy_b)
  );

  // FIFO models: write pointer owned by the stimulus, read pointer by the model.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  logic [7:0] dout_a;
  logic [7:0] pipe_b [3];

  assign bus_a.fifo_empty = (wp_a == rp_a);
  assign bus_b.fifo_empty = (wp_b == rp_b);
  assign bus_a.fifo_dout  = dout_a;
  assign bus_b.fifo_dout  = pipe_b[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_a <= wp_a;
    end else if (bus_a.fifo_rd_en) begin
      dout_a <= mem_a[rp_a & 255];
      rp_a   <= rp_a + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_b <= wp_b;
    end else begin
      if (bus_b.fifo_rd_en) begin
        pipe_b[0] <= mem_b[rp_b & 255];
        rp_b      <= rp_b + 1;
      end
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  // Scoreboards and bookkeeping (all written by the single initial process).
  exp_t sb_a[$];
  exp_t sb_b[$];
  int tests = 0, failed = 0;
  int cyc = 0;
  int beat_a = 0, beat_b = 0, pushed_a = 0, pushed_b = 0;
  int iss_a = 0, acc_a = 0, iss_b = 0, acc_b = 0;
  int first_v_a = -1, first_acc_a = -1, last_acc_a = -1;
  int first_v_b = -1, first_acc_b = -1, last_acc_b = -1;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] hold_a, hold_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    exp_t e;
    mem_a[wp_a & 255] = d;
    wp_a++;
    e.d = d;
    e.l = (beat_a == PL_A - 1);
    beat_a = e.l ? 0 : beat_a + 1;
    pushed_a++;
    sb_a.push_back(e);
  endtask

  task automatic push_b(input logic [7:0] d);
    exp_t e;
    mem_b[wp_b & 255] = d;
    wp_b++;
    e.d = d;
    e.l = (beat_b == PL_B - 1);
    beat_b = e.l ? 0 : beat_b + 1;
    pushed_b++;
    sb_b.push_back(e);
  endtask

  // Called at a falling edge; samples 1 time unit before the next rising edge.
  task automatic tick();
    exp_t e;
    #4;
    cyc++;
    // DUT A
    if (bus_a.m_valid && first_v_a < 0) first_v_a = cyc;
    if (stall_a) begin
      chk("a_hold_valid", bus_a.m_valid, 1);
      chk("a_hold_data", bus_a.m_data, hold_a);
    end
    stall_a = bus_a.m_valid && !bus_a.m_ready;
    hold_a  = bus_a.m_data;
    if (bus_a.fifo_rd_en) iss_a++;
    if (bus_a.m_valid && bus_a.m_ready) begin
      acc_a++;
      last_acc_a = cyc;
      if (first_acc_a < 0) first_acc_a = cyc;
      chk("a_sb_nonempty", (sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a_data", bus_a.m_data, e.d);
        chk("a_last", bus_a.m_last, e.l);
      end
    end
    chk("a_outstanding_le_depth", ((iss_a - acc_a) <= LAT_A + 1), 1);
    // DUT B
    if (bus_b.m_valid && first_v_b < 0) first_v_b = cyc;
    if (stall_b) begin
      chk("b_hold_valid", bus_b.m_valid, 1);
      chk("b_hold_data", bus_b.m_data, hold_b);
    end
    stall_b = bus_b.m_valid && !bus_b.m_ready;
    hold_b  = bus_b.m_data;
    if (bus_b.fifo_rd_en) iss_b++;
    if (bus_b.m_valid && bus_b.m_ready) begin
      acc_b++;
      last_acc_b = cyc;
      if (first_acc_b < 0) first_acc_b = cyc;
      chk("b_sb_nonempty", (sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b_data", bus_b.m_data, e.d);
        chk("b_last", bus_b.m_last, e.l);
      end
    end
    chk("b_outstanding_le_depth", ((iss_b - acc_b) <= LAT_B + 1), 1);
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && (sb_a.size() != 0 || sb_b.size() != 0); i++) tick();
    chk("drain_a_left", sb_a.size(), 0);
    chk("drain_b_left", sb_b.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    int c_push;
    int acc0;
    logic [3:0] pat;
    pat = 4'b1001;
    bus_a.m_ready = 1'b0;
    bus_b.m_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_a_valid", bus_a.m_valid, 0);
    chk("rst_a_last", bus_a.m_last, 0);
    chk("rst_a_data", bus_a.m_data, 0);
    chk("rst_a_wcnt", wc_a, 0);
    chk("rst_a_pcnt", pc_a, 0);
    chk("rst_a_busy", busy_a, 0);
    chk("rst_b_valid", bus_b.m_valid, 0);
    chk("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    tick();

    // A: 16-word burst, full throughput.
    bus_a.m_ready = 1'b1;
    first_v_a = -1; first_acc_a = -1;
    c_push = cyc;
    for (int i = 0; i < 16; i++) push_a(8'(i));
    drain(100);
    // empty falls in cycle c_push+1; valid appears RD_LAT+1 cycles later
    chk("a_first_valid_latency", first_v_a - (c_push + 1), LAT_A + 1);
    chk("a_burst_no_gap", last_acc_a - first_acc_a, 15);
    chk("a_burst_wcnt", wc_a, 16);
    chk("a_burst_pcnt", pc_a, 1);
    chk("a_burst_busy_after", busy_a, 0);
    chk("a_burst_valid_after", bus_a.m_valid, 0);

    // A: FIFO runs dry after 5 words of a packet, then 11 more arrive.
    for (int i = 0; i < 5; i++) push_a(8'h30 + 8'(i));
    drain(50);
    repeat (5) tick();
    chk("a_split_pcnt_mid", pc_a, 1);
    chk("a_split_wcnt_mid", wc_a, 21);
    for (int i = 5; i < 16; i++) push_a(8'h30 + 8'(i));
    drain(80);
    chk("a_split_pcnt", pc_a, 2);
    chk("a_split_wcnt", wc_a, 32);

    // A: backpressure with m_ready pattern 1,0,0,1,...
    for (int i = 0; i < 8; i++) push_a(8'h20 + 8'(i));
    for (int i = 0; i < 200 && sb_a.size() != 0; i++) begin
      bus_a.m_ready = pat[i % 4];
      tick();
    end
    chk("a_bp_left", sb_a.size(), 0);
    bus_a.m_ready = 1'b1;
    tick();
    chk("a_bp_wcnt", wc_a, 40);
    chk("a_bp_pcnt", pc_a, 2);
    chk("a_bp_busy", busy_a, 0);

    // B: 17 single-word packets, counters wrap at 16.
    bus_b.m_ready = 1'b1;
    first_v_b = -1;
    c_push = cyc;
    for (int i = 0; i < 17; i++) push_b(8'h40 + 8'(i));
    drain(100);
    chk("b_first_valid_latency", first_v_b - (c_push + 1), LAT_B + 1);
    chk("b_wrap_wcnt", wc_b, 1);
    chk("b_wrap_pcnt", pc_b, 1);
    chk("b_wrap_busy", busy_b, 0);

    // B: 100 words back to back with RD_LAT=3.
    first_acc_b = -1;
    acc0 = acc_b;
    for (int i = 0; i < 100; i++) push_b(8'(i * 3));
    drain(300);
    chk("b_thru_count", acc_b - acc0, 100);
    chk("b_thru_span", last_acc_b - first_acc_b, 99);
    chk("b_thru_wcnt", wc_b, 4'(pushed_b));
    chk("b_thru_pcnt", pc_b, 4'(pushed_b));

    // B: reset with 2 words buffered and 1 in flight.
    bus_b.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_b(8'h70 + 8'(i));
    repeat (5) tick();
    chk("b_pre_rst_valid", bus_b.m_valid, 1);
    chk("b_pre_rst_busy", busy_b, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("b_rst_valid_async", bus_b.m_valid, 0);
    chk("b_rst_busy", busy_b, 0);
    chk("b_rst_wcnt", wc_b, 0);
    chk("b_rst_data", bus_b.m_data, 0);
    chk("b_rst_rden", bus_b.fifo_rd_en, 0);
    chk("a_rst_wcnt", wc_a, 0);
    chk("a_rst_pcnt", pc_a, 0);
    sb_a.delete(); sb_b.delete();
    beat_a = 0; beat_b = 0; pushed_a = 0; pushed_b = 0;
    iss_a = 0; acc_a = 0; iss_b = 0; acc_b = 0;
    stall_a = 1'b0; stall_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_b.m_ready = 1'b1;
    repeat (10) tick();
    chk("b_post_rst_wcnt", wc_b, 0);
    chk("b_post_rst_busy", busy_b, 0);

    // Both recover cleanly after reset.
    push_a(8'hA5); push_a(8'h5A);
    push_b(8'hC3);
    drain(50);
    chk("a_recover_wcnt", wc_a, 2);
    chk("b_recover_wcnt", wc_b, 1);
    chk("b_recover_pcnt", pc_b, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
